// File: rtl/food_placer.sv
// Food-box placement engine: draws grid cells from a free-running LFSR by rejection
// sampling, queries the snake-body occupancy logic, and commits or retries.
module food_placer #(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned X_ORIGIN  = 100,
  parameter int unsigned Y_ORIGIN  = 100,
  parameter int unsigned CELL_SIZE = 8,
  parameter int unsigned X_CELLS   = 100,
  parameter int unsigned Y_CELLS   = 60,
  parameter int unsigned RST_X     = 340,
  parameter int unsigned RST_Y     = 332,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 15
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_drive,
  input  logic               I_seed_load,
  input  logic [15:0]        I_seed,
  output logic               O_chk_req,
  output logic [COORD_W-1:0] O_chk_x,
  output logic [COORD_W-1:0] O_chk_y,
  input  logic               I_chk_hit,
  output logic [COORD_W-1:0] rand_x,
  output logic [COORD_W-1:0] rand_y,
  output logic               O_busy,
  output logic               O_done,
  output logic               O_fail
);

  localparam int unsigned XW = (X_CELLS > 1) ? $clog2(X_CELLS) : 1;
  localparam int unsigned YW = (Y_CELLS > 1) ? $clog2(Y_CELLS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StGenX,
    StGenY,
    StCheck,
    StWait
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         tries_q, tries_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [XW-1:0]      idx_x_q;
  logic [COORD_W-1:0] chk_x_q, chk_y_q;
  logic [COORD_W-1:0] rand_x_q, rand_y_q;
  logic               done_q, fail_q;

  logic [XW-1:0]      cand_x;
  logic [YW-1:0]      cand_y;
  logic               x_ok, y_ok;
  logic               load_x, load_y, commit, give_up;

  function automatic logic [COORD_W-1:0] to_pix(input int unsigned origin,
                                                input int unsigned idx);
    to_pix = COORD_W'(origin + idx * CELL_SIZE);
  endfunction

  // LFSR next value: seed load wins over the Galois step; a zero seed would lock up.
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    if (I_seed_load) begin
      lfsr_d = (I_seed == 16'h0000) ? 16'h0001 : I_seed;
    end
  end

  assign cand_x = lfsr_q[XW-1:0];
  assign cand_y = lfsr_q[YW-1:0];
  assign x_ok   = (32'(cand_x) < X_CELLS);
  assign y_ok   = (32'(cand_y) < Y_CELLS);

  // Next-state and datapath strobes for the search FSM.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    load_x  = 1'b0;
    load_y  = 1'b0;
    commit  = 1'b0;
    give_up = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_drive) begin
          state_d = StGenX;
          tries_d = '0;
        end
      end
      StGenX: begin
        if (x_ok) begin
          load_x  = 1'b1;
          state_d = StGenY;
        end
      end
      StGenY: begin
        if (y_ok) begin
          load_y  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: state_d = StWait;
      StWait: begin
        if (!I_chk_hit) begin
          commit  = 1'b1;
          state_d = StIdle;
        end else if (32'(tries_q) + 32'd1 < MAX_TRIES) begin
          tries_d = tries_q + 8'd1;
          state_d = StGenX;
        end else begin
          give_up = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, LFSR and retry counter state.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= StIdle;
      tries_q <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Candidate capture, committed coordinate and result pulses.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      idx_x_q  <= '0;
      chk_x_q  <= '0;
      chk_y_q  <= '0;
      rand_x_q <= COORD_W'(RST_X);
      rand_y_q <= COORD_W'(RST_Y);
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      if (load_x) begin
        idx_x_q <= cand_x;
      end
      // The query coordinate is latched on entry to CHECK and held until the next one.
      if (load_y) begin
        chk_x_q <= to_pix(X_ORIGIN, 32'(idx_x_q));
        chk_y_q <= to_pix(Y_ORIGIN, 32'(cand_y));
      end
      if (commit) begin
        rand_x_q <= chk_x_q;
        rand_y_q <= chk_y_q;
      end
      done_q <= commit;
      fail_q <= give_up;
    end
  end

  assign O_chk_req = (state_q == StCheck);
  assign O_chk_x   = chk_x_q;
  assign O_chk_y   = chk_y_q;
  assign O_busy    = (state_q != StIdle);
  assign O_done    = done_q;
  assign O_fail    = fail_q;
  assign rand_x    = rand_x_q;
  assign rand_y    = rand_y_q;

endmodule
